mem_access_unit: RTL
====================

# mem_access_unit

Sequential load/store unit at the data-memory side of the control interface: it consumes the access width/sign code (funct3, the same code the decoder emits as LOAD_sel), address and store data from the execute stage. It runs a valid/ready transaction on the data-memory/MMIO bus and returns aligned, sign- or zero-extended load data to writeback. It stalls the pipeline while a transaction is in flight.

## Interface
- ADDR_W, 32, byte-address width
- DATA_W, 32, bus data width (fixed 32; parameter exists only for package sharing)
- clk in 1, rising-edge clock
- rst in 1, reset; synchronous, active-low
- req_valid in 1, execute stage presents a load/store
- req_ready out 1, unit can accept (high only in IDLE)
- req_we in 1, 1 = store, 0 = load
- req_funct3 in 3, width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr in ADDR_W, byte address (rs1 + imm)
- req_wdata in 32, store data (rs2)
- req_rd in 5, load destination register
- stall out 1, hold fetch/decode
- mem_valid out 1, mem_ready in 1, bus request handshake
- mem_addr out ADDR_W, word-aligned address (addr[1:0] = 00)
- mem_wstrb out 4, byte write strobes (0000 for loads)
- mem_wdata out 32, lane-replicated store data
- mem_rsp_valid in 1, mem_rdata in 32, load response
- wb_valid out 1, wb_rd out 5, wb_data out 32, writeback result
- misalign out 1, misaligned-access pulse (present only with MISALIGN_TRAP_EN)

## Operation
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- IDLE: req_ready = 1. On req_valid, latch we/funct3/addr/wdata/rd and go to REQ.
- REQ: mem_valid = 1. mem_addr, mem_wstrb and mem_wdata stay stable until mem_ready. On handshake, a store goes to IDLE; a load goes to WAIT_RSP.
- WAIT_RSP: on mem_rsp_valid, register the extracted data and go to DONE. mem_rsp_valid is ignored in every other state.
- DONE: wb_valid = 1 for exactly one cycle, then go to IDLE.
- stall = (state != IDLE).
- Store strobes:
  - SB: 0001 << addr[1:0], with data byte replicated x4.
  - SH: 0011 << {addr[1],0}, with halfword replicated x2.
  - SW: 1111.
  - funct3 other than 000/001 is treated as SW.
- Load extract:
  - Byte selected by addr[1:0]; halfword selected by addr[1].
  - 000/001 sign-extend; 100/101 zero-extend.
  - Any other funct3 is treated as LW.
- Without the macro, misalignment is silently truncated: H ignores addr[0], W ignores addr[1:0].
- Reset: all outputs 0, state = IDLE, latched request cleared. A response arriving after reset is dropped.

## Timing
- Accept cycle = T. mem_valid is first high at T+1.
- Load with zero-wait bus (mem_ready = 1 at T+1, mem_rsp_valid at T+2): wb_valid at T+3. Minimum load latency is 3 cycles.
- Store with mem_ready = 1 at T+1: IDLE and req_ready at T+2.
- Backpressure: mem_valid is held for every cycle mem_ready = 0, with bus outputs unchanged.
- A response in the same cycle as the mem_ready handshake is not accepted. The earliest accepted response is the following cycle.
- Reset asserted in any state forces IDLE on the next edge and aborts the in-flight transaction. wb_valid is not produced for it.

## Configuration
- MISALIGN_TRAP_EN defined:
  - A misaligned request (H with addr[0] = 1; W with addr[1:0] != 00) is accepted in IDLE.
  - No bus transaction is issued and no wb_valid is produced.
  - misalign pulses for one cycle at T+1, then the unit returns to IDLE at T+2.
- MISALIGN_TRAP_EN undefined: the misalign port and its logic are absent, and truncation rules apply.

## Structure
- Package mem_access_pkg: FSM state enum; width codes (W_B, W_H, W_W, W_BU, W_HU) matching the funct3 definitions in Opcode.vh; strobe-generation function.
- Sub-module load_align: combinational byte/half select plus sign/zero extension (inputs rdata, addr[1:0], funct3; output 32-bit data). It is instantiated once, on the WAIT_RSP capture path.

## Test plan
- LB at addr 0x10000003, bus rdata 0x80FF7F01 -> wb_data 0xFFFFFF80, wb_rd echoed, wb_valid at T+3.
- LHU at addr 0x10000002, rdata 0x8001ABCD -> wb_data 0x00008001. Same access as LH -> 0xFFFF8001.
- SB at addr 0x10000002, wdata 0x000000A5 -> mem_wstrb 0100, mem_wdata 0xA5A5A5A5, mem_addr 0x10000000. No wb_valid.
- SW with mem_ready held low 4 cycles -> mem_valid and bus outputs stable for 5 cycles, stall high throughout, req_ready high the cycle after the handshake.
- Reset pulled low during WAIT_RSP, with mem_rsp_valid arriving 1 cycle later -> all outputs 0, no wb_valid, next request served normally.
- LW at addr 0x10000002:
  - With MISALIGN_TRAP_EN: misalign = 1 at T+1, mem_valid never high.
  - Without it: mem_addr 0x10000000, full word returned.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, funct3 width
// codes, access-size decode, store strobe and lane replication functions.
package mem_access_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP,
    DONE
  } state_t;

  localparam logic [2:0] W_B  = 3'b000;
  localparam logic [2:0] W_H  = 3'b001;
  localparam logic [2:0] W_W  = 3'b010;
  localparam logic [2:0] W_BU = 3'b100;
  localparam logic [2:0] W_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_t;

  // Stores only know B/H; every other store code is a word store.
  function automatic size_t access_size(input logic we, input logic [2:0] funct3);
    case (funct3)
      W_B:     return SZ_B;
      W_H:     return SZ_H;
      W_W:     return SZ_W;
      W_BU:    return we ? SZ_W : SZ_B;
      W_HU:    return we ? SZ_W : SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic [3:0] strobe_gen(input size_t size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    return 4'b0001 << addr_lo;
      SZ_H:    return 4'b0011 << {addr_lo[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_replicate(input size_t size, input logic [31:0] wdata);
    case (size)
      SZ_B:    return {4{wdata[7:0]}};
      SZ_H:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_t size, input logic [1:0] addr_lo);
    return ((size == SZ_H) && addr_lo[0]) || ((size == SZ_W) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request, data-bus and writeback signals of the load/store unit.
// The misalign pulse exists only when MISALIGN_TRAP_EN is defined.
interface mem_access_unit_if #(
  parameter int ADDR_W = mem_access_pkg::ADDR_W
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [4:0]        req_rd;
  logic              stall;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_wdata;
  logic              mem_rsp_valid;
  logic [31:0]       mem_rdata;
  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_data;
`ifdef MISALIGN_TRAP_EN
  logic              misalign;
`endif

  // master: the load/store unit itself; slave: pipeline plus memory side.
  modport master (
`ifdef MISALIGN_TRAP_EN
    output misalign,
`endif
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    input  mem_ready, mem_rsp_valid, mem_rdata,
    output req_ready, stall,
    output mem_valid, mem_addr, mem_wstrb, mem_wdata,
    output wb_valid, wb_rd, wb_data
  );

  modport slave (
`ifdef MISALIGN_TRAP_EN
    input  misalign,
`endif
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    output mem_ready, mem_rsp_valid, mem_rdata,
    input  req_ready, stall,
    input  mem_valid, mem_addr, mem_wstrb, mem_wdata,
    input  wb_valid, wb_rd, wb_data
  );

endinterface

// File: rtl/mem_access_unit_load_align.sv
// Load data alignment: picks the addressed byte/halfword out of the bus word
// and sign- or zero-extends it according to funct3.
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      W_B:     data = {{24{byte_sel[7]}}, byte_sel};
      W_BU:    data = {24'd0, byte_sel};
      W_H:     data = {{16{half_sel[15]}}, half_sel};
      W_HU:    data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Sequential load/store unit: one valid/ready bus transaction per request,
// aligned load writeback. Optional misaligned trap: MISALIGN_TRAP_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | req_ready high, waiting for a request from execute
// REQ      | mem_valid high, bus outputs frozen until mem_ready
// WAIT_RSP | load issued, waiting for mem_rsp_valid
// DONE     | wb_valid (or misalign) pulse, back to IDLE next cycle
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = mem_access_pkg::ADDR_W,
  parameter int DATA_W = mem_access_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.master bus
);

  state_t            state;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [1:0]        addr_lo_q;
  logic [4:0]        rd_q;
  logic [DATA_W-1:0] align_data;
  size_t             req_size;

  assign req_size = access_size(bus.req_we, bus.req_funct3);

  load_align u_load_align (
    .rdata   (bus.mem_rdata),
    .addr_lo (addr_lo_q),
    .funct3  (funct3_q),
    .data    (align_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      we_q           <= 1'b0;
      funct3_q       <= 3'd0;
      addr_lo_q      <= 2'd0;
      rd_q           <= 5'd0;
      bus.req_ready  <= 1'b0;
      bus.stall      <= 1'b0;
      bus.mem_valid  <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wstrb  <= 4'd0;
      bus.mem_wdata  <= 32'd0;
      bus.wb_valid   <= 1'b0;
      bus.wb_rd      <= 5'd0;
      bus.wb_data    <= 32'd0;
`ifdef MISALIGN_TRAP_EN
      bus.misalign   <= 1'b0;
`endif
    end else begin
      bus.wb_valid <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      bus.misalign <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // req_ready is registered, so the first cycle out of reset accepts nothing
          if (bus.req_ready && bus.req_valid) begin
            we_q          <= bus.req_we;
            funct3_q      <= bus.req_funct3;
            addr_lo_q     <= bus.req_addr[1:0];
            rd_q          <= bus.req_rd;
            bus.req_ready <= 1'b0;
            bus.stall     <= 1'b1;
`ifdef MISALIGN_TRAP_EN
            if (is_misaligned(req_size, bus.req_addr[1:0])) begin
              bus.misalign <= 1'b1;
              state        <= DONE;
            end else
`endif
            begin
              bus.mem_valid <= 1'b1;
              bus.mem_addr  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              bus.mem_wstrb <= bus.req_we ? strobe_gen(req_size, bus.req_addr[1:0]) : 4'd0;
              bus.mem_wdata <= bus.req_we ? lane_replicate(req_size, bus.req_wdata) : 32'd0;
              state         <= REQ;
            end
          end else begin
            bus.req_ready <= 1'b1;
          end
        end

        REQ: begin
          if (bus.mem_ready) begin
            bus.mem_valid <= 1'b0;
            if (we_q) begin
              bus.req_ready <= 1'b1;
              bus.stall     <= 1'b0;
              state         <= IDLE;
            end else begin
              state <= WAIT_RSP;
            end
          end
        end

        WAIT_RSP: begin
          if (bus.mem_rsp_valid) begin
            bus.wb_data  <= align_data;
            bus.wb_rd    <= rd_q;
            bus.wb_valid <= 1'b1;
            state        <= DONE;
          end
        end

        DONE: begin
          bus.req_ready <= 1'b1;
          bus.stall     <= 1'b0;
          state         <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
